// File: rtl/mips_pkg.sv
// Shared constants for the mem-to-execute bring-up slice: ISA encodings,
// UART FSM encodings and default widths.
package mips_pkg;

    localparam int NB_DATA_DEF = 32;
    localparam int NB_ADDR_DEF = 7;

    // Opcodes handled by decode/execute
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type function codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Receiver one-hot states (exported on rx_state_o)
    localparam logic [4:0] RX_IDLE  = 5'b00001;
    localparam logic [4:0] RX_START = 5'b00010;
    localparam logic [4:0] RX_DATA  = 5'b00100;
    localparam logic [4:0] RX_STOP  = 5'b01000;
    localparam logic [4:0] RX_DONE  = 5'b10000;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // I-type opcodes take operand B from the immediate
    function automatic logic is_itype(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) ||
               (op == OP_ORI)  || (op == OP_XORI) || (op == OP_LUI);
    endfunction

    // Logical immediates are zero-extended, everything else sign-extended
    function automatic logic is_zext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/uart_core.sv
// Baud generator plus 8N1 transmitter and 16x-oversampling receiver.
// TX and RX share one baud tick; the serial line is looped back by the top.
module uart_core
    import mips_pkg::*;
#(
    parameter int N_DATA  = 8,
    parameter int N_CLOCK = 163
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_DATA-1:0] din,
    input  logic              empty,
    output logic              read_tx,
    output logic              finish_send,
    output logic              tx_line,
    input  logic              rx_line,
    output logic [N_DATA-1:0] rx_byte,
    output logic              rx_done,
    output logic [4:0]        rx_state
);

    localparam int CW = (N_CLOCK > 1) ? $clog2(N_CLOCK) : 1;
    localparam int BW = $clog2(N_DATA);

    logic [CW-1:0] baud_cnt;
    logic          tick;

    assign tick = (baud_cnt == CW'(N_CLOCK - 1));

    // Free-running baud divider, one tick every N_CLOCK clocks
    always_ff @(posedge clock) begin
        if (reset || tick) baud_cnt <= '0;
        else               baud_cnt <= baud_cnt + 1'b1;
    end

    // ---------------- transmitter ----------------
    tx_state_t         tx_state, tx_next;
    logic [3:0]        tx_tcnt;
    logic [BW-1:0]     tx_bcnt;
    logic [N_DATA-1:0] tx_shreg;
    logic              tx_bit_end;

    assign tx_bit_end = tick && (tx_tcnt == 4'd15);

    // TX state register
    always_ff @(posedge clock) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    // TX next state: every bit lasts 16 ticks
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (!empty) tx_next = TX_START;
            TX_START: if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_bcnt == BW'(N_DATA - 1)) tx_next = TX_STOP;
            TX_STOP:  if (tx_bit_end) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    // TX line driver: idle/stop high, start low, data LSB first
    always_comb begin
        tx_line = 1'b1;
        case (tx_state)
            TX_START: tx_line = 1'b0;
            TX_DATA:  tx_line = tx_shreg[0];
            default:  tx_line = 1'b1;
        endcase
    end

    // TX datapath: tick/bit counters, shifter and handshake pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_tcnt     <= '0;
            tx_bcnt     <= '0;
            tx_shreg    <= '0;
            read_tx     <= 1'b0;
            finish_send <= 1'b0;
        end else begin
            read_tx     <= (tx_state == TX_IDLE) && !empty;
            finish_send <= (tx_state == TX_STOP) && tx_bit_end;
            if (tx_state == TX_IDLE) begin
                tx_tcnt <= '0;
                tx_bcnt <= '0;
                if (!empty) tx_shreg <= din;
            end else if (tick) begin
                tx_tcnt <= tx_tcnt + 1'b1;
            end
            if (tx_state == TX_DATA && tx_bit_end) begin
                tx_shreg <= tx_shreg >> 1;
                tx_bcnt  <= tx_bcnt + 1'b1;
            end
        end
    end

    // ---------------- receiver ----------------
    logic [4:0]        rx_st, rx_nx;
    logic [3:0]        rx_tcnt;
    logic [BW-1:0]     rx_bcnt;
    logic [N_DATA-1:0] rx_shreg;

    // RX state register
    always_ff @(posedge clock) begin
        if (reset) rx_st <= RX_IDLE;
        else       rx_st <= rx_nx;
    end

    // RX next state: mid-start check at tick 7, then one sample per 16 ticks.
    // The stop bit value is not qualified, so a framing error still delivers.
    always_comb begin
        rx_nx = rx_st;
        case (rx_st)
            RX_IDLE:  if (!rx_line) rx_nx = RX_START;
            RX_START: if (tick && rx_tcnt == 4'd7) rx_nx = rx_line ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && rx_tcnt == 4'd15 && rx_bcnt == BW'(N_DATA - 1)) rx_nx = RX_STOP;
            RX_STOP:  if (tick && rx_tcnt == 4'd15) rx_nx = RX_DONE;
            RX_DONE:  rx_nx = RX_IDLE;
            default:  rx_nx = RX_IDLE;
        endcase
    end

    // RX state is exported as-is
    always_comb begin
        rx_state = rx_st;
    end

    // RX datapath: counters, data shifter, output byte and done pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_shreg <= '0;
            rx_byte  <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_done <= (rx_st == RX_DONE);
            case (rx_st)
                RX_IDLE: begin
                    rx_tcnt <= '0;
                    rx_bcnt <= '0;
                end
                RX_START: if (tick) rx_tcnt <= (rx_tcnt == 4'd7) ? 4'd0 : rx_tcnt + 1'b1;
                RX_DATA: if (tick) begin
                    rx_tcnt <= rx_tcnt + 1'b1;
                    if (rx_tcnt == 4'd15) begin
                        rx_shreg <= {rx_line, rx_shreg[N_DATA-1:1]};
                        rx_bcnt  <= rx_bcnt + 1'b1;
                    end
                end
                RX_STOP: if (tick) rx_tcnt <= rx_tcnt + 1'b1;
                RX_DONE: rx_byte <= rx_shreg;
                default: rx_tcnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/top_mem_to_execute.sv
// Front-end bring-up: UART loopback fills instruction memory word by word,
// then fetch -> decode -> execute runs on the stored words.
module top_mem_to_execute
    import mips_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int N_DATA  = 8,
    parameter int N_CLOCK = 163,
    parameter int NB_ADDR = NB_ADDR_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_DATA-1:0]  din,
    input  logic               empty,
    output logic               read_tx,
    output logic               finish_send,
    output logic               conexion_tx_rx,
    output logic [N_DATA-1:0]  salida_de_rx,
    output logic               finish_recieve,
    output logic [4:0]         rx_state_o,
    output logic               intMem_ready,
    output logic [NB_DATA-1:0] intMem_data_o,
    input  logic               enable,
    input  logic [NB_ADDR-1:0] next_addr_i,
    input  logic               en_read_i,
    output logic [NB_ADDR-1:0] pc_o,
    output logic [NB_DATA-1:0] instruction_o,
    output logic [NB_DATA-1:0] data_o_fetch,
    output logic [NB_DATA-1:0] inmediate_o_paraver,
    output logic               tipeI_paraver,
    output logic [NB_DATA-1:0] operation_o
);

    localparam int BPW = NB_DATA / N_DATA;
    localparam int CBW = $clog2(BPW);

    uart_core #(.N_DATA(N_DATA), .N_CLOCK(N_CLOCK)) u_uart (
        .clock       (clock),
        .reset       (reset),
        .din         (din),
        .empty       (empty),
        .read_tx     (read_tx),
        .finish_send (finish_send),
        .tx_line     (conexion_tx_rx),
        .rx_line     (conexion_tx_rx),
        .rx_byte     (salida_de_rx),
        .rx_done     (finish_recieve),
        .rx_state    (rx_state_o)
    );

    // ---------------- word assembly / instruction memory ----------------
    logic [NB_DATA-1:0]        mem [2**NB_ADDR];
    logic [CBW-1:0]            byte_cnt;
    logic [NB_DATA-N_DATA-1:0] word_buf;
    logic [NB_ADDR-1:0]        waddr;
    logic [NB_DATA-1:0]        assembled;
    logic                      word_we;

    // Newest byte enters at the top, so after four bytes the first is [7:0]
    assign assembled = {salida_de_rx, word_buf};
    assign word_we   = finish_recieve && !reset && (byte_cnt == CBW'(BPW - 1));

    // Byte counter, shift buffer, write address and ready pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt     <= '0;
            word_buf     <= '0;
            waddr        <= '0;
            intMem_ready <= 1'b0;
        end else begin
            intMem_ready <= word_we;
            if (finish_recieve) begin
                word_buf <= assembled[NB_DATA-1:N_DATA];
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (word_we) waddr <= waddr + 1'b1;
        end
    end

    // Instruction memory write port; contents survive reset
    always_ff @(posedge clock) begin
        if (word_we) mem[waddr] <= assembled;
    end

    assign intMem_data_o = mem[pc_o];

    // ---------------- fetch ----------------
    // PC and instruction register, both gated by enable
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_o          <= '0;
            instruction_o <= '0;
        end else if (enable) begin
            pc_o <= next_addr_i;
            if (en_read_i) instruction_o <= intMem_data_o;
        end
    end

    assign data_o_fetch = instruction_o;

    // ---------------- decode ----------------
    logic [5:0]         opcode, funct;
    logic [4:0]         rs, rt, shamt;
    logic [NB_DATA-1:0] regfile [32];
    logic [NB_DATA-1:0] imm_ext;

    assign opcode  = instruction_o[31:26];
    assign rs      = instruction_o[25:21];
    assign rt      = instruction_o[20:16];
    assign shamt   = instruction_o[10:6];
    assign funct   = instruction_o[5:0];
    assign imm_ext = is_zext(opcode) ? {{(NB_DATA-16){1'b0}}, instruction_o[15:0]}
                                     : {{(NB_DATA-16){instruction_o[15]}}, instruction_o[15:0]};

    // Register file has no write port here; it only ever holds its reset value
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regfile[i] <= '0;
        end
    end

    logic [5:0]         op_q, funct_q;
    logic [4:0]         shamt_q;
    logic [NB_DATA-1:0] rs_val_q, rt_val_q;

    // Decode pipeline register, one cycle behind the instruction register
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q                <= '0;
            funct_q             <= '0;
            shamt_q             <= '0;
            rs_val_q            <= '0;
            rt_val_q            <= '0;
            inmediate_o_paraver <= '0;
            tipeI_paraver       <= 1'b0;
        end else begin
            op_q                <= opcode;
            funct_q             <= funct;
            shamt_q             <= shamt;
            rs_val_q            <= (rs == 5'd0) ? '0 : regfile[rs];
            rt_val_q            <= (rt == 5'd0) ? '0 : regfile[rt];
            inmediate_o_paraver <= imm_ext;
            tipeI_paraver       <= is_itype(opcode);
        end
    end

    // ---------------- execute ----------------
    logic [NB_DATA-1:0] op_b;
    assign op_b = tipeI_paraver ? inmediate_o_paraver : rt_val_q;

    // ALU: wraparound arithmetic, unknown encodings yield zero
    always_comb begin
        operation_o = '0;
        case (op_q)
            OP_RTYPE: begin
                case (funct_q)
                    FN_ADD:  operation_o = rs_val_q + op_b;
                    FN_SUB:  operation_o = rs_val_q - op_b;
                    FN_AND:  operation_o = rs_val_q & op_b;
                    FN_OR:   operation_o = rs_val_q | op_b;
                    FN_XOR:  operation_o = rs_val_q ^ op_b;
                    FN_NOR:  operation_o = ~(rs_val_q | op_b);
                    FN_SLT:  operation_o = {{(NB_DATA-1){1'b0}}, $signed(rs_val_q) < $signed(op_b)};
                    FN_SLL:  operation_o = op_b << shamt_q;
                    FN_SRL:  operation_o = op_b >> shamt_q;
                    FN_SRA:  operation_o = $signed(op_b) >>> shamt_q;
                    default: operation_o = '0;
                endcase
            end
            OP_ADDI: operation_o = rs_val_q + op_b;
            OP_SLTI: operation_o = {{(NB_DATA-1){1'b0}}, $signed(rs_val_q) < $signed(op_b)};
            OP_ANDI: operation_o = rs_val_q & op_b;
            OP_ORI:  operation_o = rs_val_q | op_b;
            OP_XORI: operation_o = rs_val_q ^ op_b;
            OP_LUI:  operation_o = {inmediate_o_paraver[15:0], 16'b0};
            default: operation_o = '0;
        endcase
    end

endmodule

// File: tb/tb_top_mem_to_execute.sv
// Directed bench: bytes go out over the UART loopback, a byte scoreboard
// checks every receive, then stored words are fetched/decoded/executed.
module tb_top_mem_to_execute;

    localparam int NCLK = 4;   // short baud period keeps the run small

    logic        clock = 1'b0;
    logic        reset, empty, enable, en_read_i;
    logic [7:0]  din;
    logic [6:0]  next_addr_i;
    logic        read_tx, finish_send, conexion_tx_rx, finish_recieve, intMem_ready, tipeI_paraver;
    logic [7:0]  salida_de_rx;
    logic [4:0]  rx_state_o;
    logic [6:0]  pc_o;
    logic [31:0] intMem_data_o, instruction_o, data_o_fetch, inmediate_o_paraver, operation_o;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_bytes [$];

    always #5 clock = ~clock;

    top_mem_to_execute #(.N_CLOCK(NCLK)) dut (
        .clock               (clock),
        .reset               (reset),
        .din                 (din),
        .empty               (empty),
        .read_tx             (read_tx),
        .finish_send         (finish_send),
        .conexion_tx_rx      (conexion_tx_rx),
        .salida_de_rx        (salida_de_rx),
        .finish_recieve      (finish_recieve),
        .rx_state_o          (rx_state_o),
        .intMem_ready        (intMem_ready),
        .intMem_data_o       (intMem_data_o),
        .enable              (enable),
        .next_addr_i         (next_addr_i),
        .en_read_i           (en_read_i),
        .pc_o                (pc_o),
        .instruction_o       (instruction_o),
        .data_o_fetch        (data_o_fetch),
        .inmediate_o_paraver (inmediate_o_paraver),
        .tipeI_paraver       (tipeI_paraver),
        .operation_o         (operation_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Send one byte, hold empty low for two cycles, run until TX finishes.
    task automatic send_byte(input logic [7:0] b, input bit last);
        int n_read = 0, n_fs = 0, n_fr = 0, n_rdy = 0, cyc = 0;
        bit done = 0;
        logic [7:0] e;
        exp_bytes.push_back(b);
        din = b;
        empty = 1'b0;
        repeat (2) begin
            @(negedge clock);
            n_read += int'(read_tx);
        end
        empty = 1'b1;
        while (!done && cyc < 200 * NCLK + 100) begin
            @(negedge clock);
            cyc++;
            n_read += int'(read_tx);
            if (finish_recieve) begin
                n_fr++;
                e = 'x;
                if (exp_bytes.size() > 0) e = exp_bytes.pop_front();
                check("rx_byte", 32'(salida_de_rx), 32'(e));
            end
            if (intMem_ready) n_rdy++;
            if (finish_send) begin
                n_fs++;
                done = 1;
            end
        end
        check("read_tx_pulses", n_read, 1);
        check("finish_send_pulses", n_fs, 1);
        check("finish_recieve_pulses", n_fr, 1);
        check("intMem_ready_pulses", n_rdy, last ? 1 : 0);
        check("frame_len_ok", 32'((cyc + 2 >= 159 * NCLK) && (cyc + 2 <= 162 * NCLK)), 1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], i == 3);
    endtask

    // Fetch addr a and check each pipeline stage at its edge
    task automatic fetch(input logic [6:0] a, input logic [31:0] w, input logic t,
                         input logic [31:0] imm, input logic [31:0] op);
        enable = 1'b1;
        en_read_i = 1'b1;
        next_addr_i = a;
        @(negedge clock);
        check("pc_o", 32'(pc_o), 32'(a));
        check("intMem_data_o", intMem_data_o, w);
        @(negedge clock);
        check("instruction_o", instruction_o, w);
        check("data_o_fetch", data_o_fetch, w);
        @(negedge clock);
        check("tipeI", 32'(tipeI_paraver), 32'(t));
        check("immediate", inmediate_o_paraver, imm);
        check("operation", operation_o, op);
        enable = 1'b0;
        en_read_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1; empty = 1'b1; din = '0;
        enable = 1'b0; en_read_i = 1'b0; next_addr_i = '0;
        @(negedge clock);
        reset = 1'b0;
        check("rst_line", 32'(conexion_tx_rx), 1);
        check("rst_rx_state", 32'(rx_state_o), 32'h01);
        check("rst_pc", 32'(pc_o), 0);
        check("rst_instr", instruction_o, 0);
        check("rst_pulses", {28'd0, read_tx, finish_send, finish_recieve, intMem_ready}, 0);
        check("rst_operation", operation_o, 0);

        // addi $1,$0,1 then an all-ones word
        send_word(32'h20010001);
        send_word(32'hFFFFFFFF);
        // ori, lui, slti (negative imm), nor
        send_word(32'h3402F0F0);
        send_word(32'h3C031234);
        send_word(32'h2804FFFF);
        send_word(32'h00000027);

        fetch(7'd0, 32'h20010001, 1'b1, 32'h00000001, 32'h00000001);
        fetch(7'd1, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 32'h00000000);
        // Disabled fetch must hold PC and instruction
        next_addr_i = 7'd5; en_read_i = 1'b1;
        @(negedge clock);
        check("hold_pc", 32'(pc_o), 1);
        check("hold_instr", instruction_o, 32'hFFFFFFFF);
        en_read_i = 1'b0;
        fetch(7'd2, 32'h3402F0F0, 1'b1, 32'h0000F0F0, 32'h0000F0F0);
        fetch(7'd3, 32'h3C031234, 1'b1, 32'h00001234, 32'h12340000);
        fetch(7'd4, 32'h2804FFFF, 1'b1, 32'hFFFFFFFF, 32'h00000000);
        fetch(7'd5, 32'h00000027, 1'b0, 32'h00000027, 32'hFFFFFFFF);

        // One stray byte, then reset in the middle of the next frame
        send_byte(8'hAA, 1'b0);
        din = 8'h55; empty = 1'b0;
        @(negedge clock);
        empty = 1'b1;
        repeat (300) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_line", 32'(conexion_tx_rx), 1);
        check("midrst_rx_state", 32'(rx_state_o), 32'h01);
        check("midrst_pc", 32'(pc_o), 0);
        check("midrst_instr", instruction_o, 0);
        check("midrst_operation", operation_o, 0);

        // Byte counter and write address restart: this word lands in mem[0]
        send_word(32'h44332211);
        fetch(7'd0, 32'h44332211, 1'b0, 32'h00002211, 32'h00000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/top_mem_to_execute.md
Name: top_mem_to_execute

Overview:
- Integration block for front-end bring-up.
- A UART transmitter takes bytes from an external FIFO-style source (`din`/`empty`) and drives them on an internal serial loopback line into a UART receiver.
- The receiver assembles bytes into 32-bit little-endian words and writes them sequentially into an instruction memory.
- A fetch stage reads that memory, a decode stage splits the instruction, and an execute ALU produces the result.

Parameters:
- NB_DATA, 32, instruction/data word width
- N_DATA, 8, UART byte width
- N_CLOCK, 163, system clocks per baud tick (16 ticks per bit; 50 MHz / 19200 baud)
- NB_ADDR, 7, instruction memory address width (128 words)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- din  in  8  byte to transmit
- empty  in  1  low = byte available on din
- read_tx  out  1  one-cycle pulse when TX accepts din
- finish_send  out  1  one-cycle pulse at end of TX stop bit
- conexion_tx_rx  out  1  serial line TX->RX (idle high)
- salida_de_rx  out  8  last byte received
- finish_recieve  out  1  one-cycle pulse per received byte
- rx_state_o  out  5  RX FSM state, one-hot
- intMem_ready  out  1  one-cycle pulse when a word is written to memory
- intMem_data_o  out  32  memory read data at pc_o (combinational)
- enable  in  1  fetch enable
- next_addr_i  in  7  next PC value
- en_read_i  in  1  latch memory data into instruction register
- pc_o  out  7  program counter
- instruction_o  out  32  instruction register
- data_o_fetch  out  32  fetch output to decode (equals instruction_o)
- inmediate_o_paraver  out  32  decoded immediate
- tipeI_paraver  out  1  decoded instruction is I-type
- operation_o  out  32  execute ALU result

Behaviour:
- **Reset values.** All outputs, counters and registers are 0, except conexion_tx_rx = 1 and rx_state_o = IDLE (5'b00001). Memory contents are not reset.
- **Baud generator.** Free-running counter; tick every N_CLOCK clocks.
- **TX.**
  - In idle, `empty == 0` → latch din, pulse read_tx, start frame.
  - Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts 16 ticks.
  - finish_send pulses when the stop bit ends; TX then returns to idle.
  - empty is ignored while busy.
- **RX FSM** (one-hot):
  - IDLE=00001: wait for the line to go low.
  - START=00010: sample at tick 7; if the line is high, go back to IDLE (glitch).
  - DATA=00100: sample each bit at tick 15, LSB first.
  - STOP=01000: sample the stop bit.
  - DONE=10000: update salida_de_rx, pulse finish_recieve, return to IDLE.
  - A bad stop bit (0) still completes the byte.
- **Word assembly.**
  - The first received byte becomes bits [7:0]; the fourth becomes [31:24].
  - On the fourth byte: write mem[waddr], pulse intMem_ready, then waddr++ (wraps at 127 → 0).
  - The byte counter resets only on reset.
- **Fetch.**
  - `enable == 1` → pc_o <= next_addr_i.
  - intMem_data_o = mem[pc_o].
  - `enable && en_read_i` → instruction_o <= intMem_data_o; otherwise it holds.
- **Decode** (registered, one cycle after instruction_o):
  - Fields: opcode [31:26], rs, rt, rd, shamt, funct.
  - Register file is 32x32, reset to zero, read-only in this block; reg 0 is always 0.
  - tipeI = 1 for opcodes 0x08 addi, 0x0A slti, 0x0C andi, 0x0D ori, 0x0E xori, 0x0F lui; 0 otherwise.
  - Immediate: zero-extended for andi/ori/xori, sign-extended otherwise.
- **Execute** (combinational from decode registers):
  - Operand B is the immediate if tipeI, else rt.
  - R-type funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt, 0x00 sll, 0x02 srl, 0x03 sra (shift by shamt).
  - lui → {imm[15:0], 16'b0}.
  - Unknown opcode or funct → 0.
  - Arithmetic is 32-bit wraparound with no overflow trap.
- **Latency** from enable with next_addr_i: pc_o at edge 1, instruction_o at edge 2, decode outputs/operation_o at edge 3.
- **Reset mid-frame** aborts TX/RX, clears the byte counter and waddr, and returns conexion_tx_rx to 1.

Decomposition:
- Package `mips_pkg` holds:
  - opcode and funct localparams;
  - RX one-hot state constants;
  - NB_DATA / NB_ADDR defaults.
- Natural sub-module: `uart_core` (baud generator + TX + RX). Memory, fetch, decode and ALU stay in the top.

Test Plan:
1. Reset for 1 cycle → conexion_tx_rx = 1, rx_state_o = 00001, pc_o = 0, instruction_o = 0, all pulses low.
2. din = 0x01, empty low for 2 cycles → exactly one read_tx pulse; finish_send after 160·N_CLOCK cycles; finish_recieve with salida_de_rx = 0x01.
3. Send bytes 01,00,01,20 → one intMem_ready pulse; mem[0] = 0x20010001.
4. Then send FF x4 → mem[1] = 0xFFFFFFFF. Then enable = 1, next_addr_i = 0, en_read_i = 1 → after 2 cycles instruction_o = data_o_fetch = 0x20010001.
5. One cycle later → tipeI_paraver = 1, inmediate_o_paraver = 0x00000001, operation_o = 0x00000001.
6. next_addr_i = 1 → instruction_o = 0xFFFFFFFF, tipeI_paraver = 0, operation_o = 0.
